// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with single-line refill, whole-cache flush (fence.i)
// and a one-cycle hit path that can accept back-to-back fetches.
module icache_dm #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESPOND, S_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:2]        r_pc;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS*LINE_WORDS];
  logic [OFF_W-1:0]   r_beat;
  logic [IDX_W-1:0]   r_fcnt;
  logic               r_flush_pend;

  logic [OFF_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [31:0]        w_word;
  logic               w_req_ready;
  logic               w_resp_valid;
  logic               w_mem_req_valid;
  logic               w_accept;
  logic               w_unused_addr_lsb;

  assign w_off  = r_pc[2 +: OFF_W];
  assign w_idx  = r_pc[2+OFF_W +: IDX_W];
  assign w_tag  = r_pc[31 -: TAG_W];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word = r_data[{w_idx, w_off}];
  assign w_accept = req_valid && w_req_ready;
  assign w_unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    w_next          = r_state;
    w_req_ready     = 1'b0;
    w_resp_valid    = 1'b0;
    w_mem_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !flush;
        if (flush)          w_next = S_FLUSH;
        else if (req_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_resp_valid = 1'b1;
          w_req_ready  = !flush;
          if (flush)          w_next = S_FLUSH;
          else if (req_valid) w_next = S_LOOKUP;
          else                w_next = S_IDLE;
        end else begin
          w_next = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        w_mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = S_REFILL;
      end
      S_REFILL: begin
        if (mem_resp_valid && (r_beat == LAST_BEAT)) w_next = S_RESPOND;
      end
      S_RESPOND: begin
        w_resp_valid = 1'b1;
        w_next = (r_flush_pend || flush) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (r_fcnt == LAST_SET) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are forced to their idle values while reset is asserted.
  assign req_ready     = rst | w_req_ready;
  assign resp_valid    = !rst && w_resp_valid;
  assign resp_data     = resp_valid ? w_word : 32'h0;
  assign mem_req_valid = !rst && w_mem_req_valid;
  assign mem_req_addr  = mem_req_valid ? {r_pc[31:2+OFF_W], {(OFF_W+2){1'b0}}} : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_beat       <= '0;
      r_fcnt       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_MISS_REQ: if (mem_req_ready) r_beat <= '0;
        S_REFILL: begin
          if (mem_resp_valid) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) r_valid[w_idx] <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_valid[r_fcnt] <= 1'b0;
          r_fcnt          <= r_fcnt + 1'b1;
        end
        default: ;
      endcase
      // A flush that cannot start now is remembered until the current miss has responded.
      if (w_next == S_FLUSH)
        r_flush_pend <= 1'b0;
      else if (flush && ((r_state == S_MISS_REQ) || (r_state == S_REFILL) ||
                         ((r_state == S_LOOKUP) && !w_hit)))
        r_flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pc <= req_addr[31:2];
    if ((r_state == S_REFILL) && mem_resp_valid) begin
      r_data[{w_idx, r_beat}] <= mem_resp_data;
      if (r_beat == LAST_BEAT) r_tag[w_idx] <= w_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a transaction-level cache model checked every cycle,
// plus literal expectations for the cold-miss, hit, conflict, backpressure, flush and reset cases.
module tb_icache_dm;
  localparam int SETS = 64;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        flush = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        req_ready, resp_valid, mem_req_valid;
  logic [31:0] resp_data, mem_req_addr;

  int n_vec = 0;
  int n_err = 0;

  icache_dm #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    return {8'hC5, a[23:0]};
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (4 * LW)) % SETS);
  endfunction

  function automatic int off_of(input logic [31:0] a);
    return int'((a / 4) % LW);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * LW * SETS);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % (4 * LW));
  endfunction

  // Model: cache contents plus the outstanding activity (lookup-miss, refill, respond, flush).
  bit          m_valid [SETS];
  logic [31:0] m_tag   [SETS];
  logic [31:0] m_data  [SETS][LW];
  logic [31:0] m_line  [LW];
  int          m_flush_left = 0;
  int          m_beats = 0;
  bit          m_lkmiss = 0, m_miss = 0, m_sent = 0, m_respond = 0, m_pend = 0;
  logic [31:0] m_addr = 32'h0;
  bit          e_resp = 0;
  logic [31:0] e_data = 32'h0;

  task automatic start_flush();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_flush_left = SETS;
    m_pend = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
      m_flush_left = 0; m_lkmiss = 0; m_miss = 0; m_sent = 0;
      m_respond = 0; m_pend = 0; e_resp = 0;
      return;
    end
    e_resp = 0;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_lkmiss) begin
      m_lkmiss = 0; m_miss = 1; m_sent = 0; m_beats = 0;
      if (flush) m_pend = 1;
    end else if (m_miss) begin
      if (flush) m_pend = 1;
      if (!m_sent) begin
        if (mem_req_ready) m_sent = 1;
      end else if (mem_resp_valid) begin
        m_line[m_beats] = mem_resp_data;
        m_beats++;
        if (m_beats == LW) begin
          m_valid[idx_of(m_addr)] = 1'b1;
          m_tag[idx_of(m_addr)]   = tag_of(m_addr);
          for (int w = 0; w < LW; w++) m_data[idx_of(m_addr)][w] = m_line[w];
          m_miss = 0; m_respond = 1;
          e_resp = 1; e_data = m_line[off_of(m_addr)];
        end
      end
    end else if (m_respond) begin
      m_respond = 0;
      if (m_pend || flush) start_flush();
    end else begin
      if (flush) start_flush();
      else if (req_valid) begin
        m_addr = req_addr;
        if (m_valid[idx_of(req_addr)] && m_tag[idx_of(req_addr)] == tag_of(req_addr)) begin
          e_resp = 1; e_data = m_data[idx_of(req_addr)][off_of(req_addr)];
        end else begin
          m_lkmiss = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_req_ready", {31'b0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_mem_req_addr", mem_req_addr, 32'h0);
    end else begin
      check("req_ready", {31'b0, req_ready},
            {31'b0, !(m_lkmiss || m_miss || m_respond || (m_flush_left > 0)) && !flush});
      check("resp_valid", {31'b0, resp_valid}, {31'b0, e_resp});
      if (e_resp) check("resp_data", resp_data, e_data);
      check("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, m_miss && !m_sent});
      if (m_miss && !m_sent) check("mem_req_addr", mem_req_addr, line_of(m_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] exp_word,
                       input int stall, input int gap, input int flush_beat, input int nbeats);
    int t = 0;
    while (!mem_req_valid && t < 20) begin
      tick();
      t++;
    end
    check("refill_req", {31'b0, mem_req_valid}, 32'h1);
    check("refill_addr", mem_req_addr, exp_addr);
    repeat (stall) begin
      tick();
      check("addr_stable", mem_req_addr, exp_addr);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int w = 0; w < nbeats; w++) begin
      repeat (gap) tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(exp_addr + 32'(4 * w));
      flush          = (w == flush_beat);
      tick();
      mem_resp_valid = 1'b0;
      flush          = 1'b0;
    end
    if (nbeats == LW) begin
      check("miss_resp_valid", {31'b0, resp_valid}, 32'h1);
      check("miss_resp_word", resp_data, exp_word);
    end
  endtask

  task automatic count_flush(input string name);
    int cnt = 0;
    while (!req_ready && cnt < 200) begin
      cnt++;
      tick();
    end
    check(name, 32'(cnt), 32'd64);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_lit_ready", {31'b0, req_ready}, 32'h1);
    check("rst_lit_memreq", {31'b0, mem_req_valid}, 32'h0);
    rst = 1'b0;
    tick();

    // cold miss
    req(32'h104);
    check("cold_no_resp", {31'b0, resp_valid}, 32'h0);
    serve(32'h100, 32'hA1, 0, 0, -1, LW);
    tick();

    // back-to-back hits
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h100 + 32'(4 * i);
      tick();
      check("hit_valid", {31'b0, resp_valid}, 32'h1);
      check("hit_data", resp_data, 32'hA0 + 32'(i));
      check("hit_no_memreq", {31'b0, mem_req_valid}, 32'h0);
    end
    req_valid = 1'b0;
    tick();

    // conflict on index 0x10
    req(32'h500);
    serve(32'h500, 32'hC500_0500, 0, 0, -1, LW);
    tick();
    req(32'h100);
    check("conflict_miss", {31'b0, resp_valid}, 32'h0);
    serve(32'h100, 32'hA0, 0, 0, -1, LW);
    tick();

    // backpressure and beat gaps
    req(32'h20C);
    serve(32'h200, 32'hC500_020C, 5, 2, -1, LW);
    tick();

    // flush from idle
    flush = 1'b1;
    tick();
    flush = 1'b0;
    count_flush("flush_cycles");
    req(32'h104);
    check("post_flush_miss", {31'b0, resp_valid}, 32'h0);
    serve(32'h100, 32'hA1, 0, 0, -1, LW);
    tick();

    // flush raised mid-refill runs after the response
    req(32'h604);
    serve(32'h600, 32'hC500_0604, 0, 1, 1, LW);
    tick();
    count_flush("pend_flush_cycles");
    req(32'h104);
    check("pend_flush_miss", {31'b0, resp_valid}, 32'h0);
    serve(32'h100, 32'hA1, 0, 0, -1, LW);
    tick();

    // reset in the middle of a refill
    req(32'h20C);
    serve(32'h200, 32'h0, 0, 0, -1, 2);
    rst = 1'b1;
    tick();
    check("midrst_ready", {31'b0, req_ready}, 32'h1);
    check("midrst_resp", {31'b0, resp_valid}, 32'h0);
    check("midrst_memreq", {31'b0, mem_req_valid}, 32'h0);
    check("midrst_addr", mem_req_addr, 32'h0);
    check("midrst_data", resp_data, 32'h0);
    rst = 1'b0;
    for (int w = 2; w < LW; w++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_0000 + 32'(w);
      tick();
    end
    mem_resp_valid = 1'b0;
    check("after_rst_ready", {31'b0, req_ready}, 32'h1);
    check("after_rst_resp", {31'b0, resp_valid}, 32'h0);
    req(32'h104);
    check("after_rst_miss", {31'b0, resp_valid}, 32'h0);
    serve(32'h100, 32'hA1, 0, 0, -1, LW);
    tick();
    req(32'h20C);
    check("abandoned_line_miss", {31'b0, resp_valid}, 32'h0);
    serve(32'h200, 32'hC500_020C, 0, 0, -1, LW);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter SETS, default 64, number of lines; power of two, at least 2.
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line; power of two, at least 2.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port req_valid, input, 1, fetch request from core.
REQ-006 Port req_addr, input, 32, fetch byte address (pc); bits [1:0] ignored.
REQ-007 Port req_ready, output, 1, cache accepts a request this cycle.
REQ-008 Port resp_valid, output, 1, resp_data holds the instruction; one-cycle pulse.
REQ-009 Port resp_data, output, 32, fetched instruction word.
REQ-010 Port flush, input, 1, invalidate all lines (fence.i).
REQ-011 Port mem_req_valid, output, 1, line refill request to memory.
REQ-012 Port mem_req_addr, output, 32, line-aligned refill byte address.
REQ-013 Port mem_req_ready, input, 1, memory accepts the refill request.
REQ-014 Port mem_resp_valid, input, 1, refill beat valid.
REQ-015 Port mem_resp_data, input, 32, refill beat data, ascending word order.

Function
REQ-016 Address split: word offset = addr[2+log2(LINE_WORDS)-1:2]; index = next log2(SETS) bits; tag = remaining upper bits.
REQ-017 Storage: per line one valid bit, one tag, and LINE_WORDS data words.
REQ-018 State machine: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND, FLUSH.
REQ-019 IDLE: req_ready=1. A request is accepted when req_valid=1; the address is latched and the FSM goes to LOOKUP.
REQ-020 LOOKUP, hit (valid and tag match): resp_valid=1 with the addressed word; req_ready=1; back-to-back acceptance is allowed, giving one response per cycle.
REQ-021 Hit latency: response in the cycle after acceptance.
REQ-022 LOOKUP, miss: no response; go to MISS_REQ; req_ready=0.
REQ-023 MISS_REQ: mem_req_valid=1 with mem_req_addr = latched address with the offset and bits [1:0] zeroed.
REQ-024 MISS_REQ: mem_req_valid and mem_req_addr stay stable until mem_req_ready=1; then go to REFILL.
REQ-025 REFILL: each mem_resp_valid beat writes the next word, using a beat counter from 0 to LINE_WORDS-1.
REQ-026 REFILL: beats may have gaps; mem_resp_valid outside REFILL is ignored.
REQ-027 REFILL: on the last beat, write the tag, set valid, and go to RESPOND.
REQ-028 RESPOND: resp_valid=1 with the originally requested word; go to IDLE. Miss latency = 2 + handshake wait + refill cycles.
REQ-029 resp_valid is never asserted in IDLE, MISS_REQ, REFILL or FLUSH.
REQ-030 flush sampled in IDLE, or in LOOKUP on a hit cycle: go to FLUSH, which clears one set per cycle via an index counter.
REQ-031 FLUSH: takes exactly SETS cycles; req_ready=0; return to IDLE.
REQ-032 flush in IDLE has priority over req_valid; that request is not accepted.
REQ-033 flush during MISS_REQ or REFILL: held pending in a sticky bit; the refill completes and its response is delivered, then FLUSH runs.
REQ-034 Lines with index counter wrap-around: the last set clears at counter SETS-1, and the counter returns to 0.
REQ-035 Data and tag arrays are not reset; only valid bits determine hit.

Reset
REQ-036 rst=1 at an edge forces IDLE, clears all valid bits in that cycle, and clears the beat counter, flush counter and pending-flush bit.
REQ-037 Output values during and after reset: req_ready=1, resp_valid=0, mem_req_valid=0, resp_data=0, mem_req_addr=0.
REQ-038 rst mid-refill abandons the line: it stays invalid, and later beats are ignored.

Verification
REQ-039 Cold miss: after reset, request 0x0000_0104 -> mem_req_addr=0x0000_0100; beats 0xA0..0xA3 -> resp_data=0xA1, in RESPOND.
REQ-040 Hit after fill: requests 0x100, 0x104, 0x108, 0x10C on consecutive cycles -> four consecutive resp_valid pulses carrying 0xA0..0xA3, with no mem_req_valid.
REQ-041 Conflict: fill 0x100, then request 0x500 (same index, tag differs) -> refill at 0x500; a later request to 0x100 misses again.
REQ-042 Backpressure/gaps: hold mem_req_ready=0 for 5 cycles and insert 2-cycle gaps between beats -> address stable throughout; correct word returned.
REQ-043 Flush: flush with SETS=64 -> req_ready=0 for 64 cycles; then request 0x104 misses.
REQ-044 Reset mid-refill: rst after 2 beats -> outputs at reset values; request 0x104 misses and refills.
